hwpe_stream_sink_job_sequencer: RTL and testbench

- Queues streamer jobs and runs them one at a time on a single hwpe_stream_sink (or source) instance, so the engine FSM can post several transfers back-to-back.
- For the head job: drives addressgen configuration, pulses req_start, waits for the sink's done flag, then retires the job and issues the next.
- Sits between engine control and the streamer ctrl_i/flags_o ports. Provides a per-job completion event and a done-watchdog.

---
 rtl/hwpe_stream_package.sv | 25 ++
 rtl/hwpe_stream_job_fifo.sv | 63 ++++++
 rtl/hwpe_stream_sink_job_sequencer.sv | 155 +++++++++++++++
 tb/tb_hwpe_stream_sink_job_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_package.sv
`default_nettype none
// ============================================================================
// hwpe_stream_package: shared FSM state and job-record types for the
// streamer job sequencer.  Revision: 1.0
// ============================================================================
package hwpe_stream_package;

  localparam int unsigned JOB_TRANS_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    SKIP  = 2'd3
  } job_sequencer_state_t;

  typedef struct packed {
    logic [31:0]                base_addr;
    logic [JOB_TRANS_WIDTH-1:0] trans_size;
    logic [15:0]                line_stride;
    logic [JOB_TRANS_WIDTH-1:0] line_length;
  } ctrl_job_t;

endpackage
`default_nettype wire

// File: rtl/hwpe_stream_job_fifo.sv
`default_nettype none
// ============================================================================
// hwpe_stream_job_fifo: register-array FIFO of ctrl_job_t records with
// occupancy count and synchronous soft clear.  Revision: 1.0
// ============================================================================
module hwpe_stream_job_fifo
  import hwpe_stream_package::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  ctrl_job_t              data_i,
  input  logic                   pop_i,
  output ctrl_job_t              data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  ctrl_job_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/hwpe_stream_sink_job_sequencer.sv
`default_nettype none
// ============================================================================
// hwpe_stream_sink_job_sequencer: queues streamer jobs and runs them one at a
// time (config, start, wait done, retire) with a done-watchdog.  Revision: 1.0
// ============================================================================
module hwpe_stream_sink_job_sequencer
  import hwpe_stream_package::*;
#(
  parameter int unsigned JOB_FIFO_DEPTH = 4,
  parameter int unsigned TRANS_WIDTH    = 16,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              job_valid_i,
  output logic                              job_ready_o,
  input  logic [31:0]                       job_base_addr_i,
  input  logic [TRANS_WIDTH-1:0]            job_trans_size_i,
  input  logic [15:0]                       job_line_stride_i,
  input  logic [TRANS_WIDTH-1:0]            job_line_length_i,
  output logic [31:0]                       base_addr_o,
  output logic [TRANS_WIDTH-1:0]            trans_size_o,
  output logic [15:0]                       line_stride_o,
  output logic [TRANS_WIDTH-1:0]            line_length_o,
  output logic                              req_start_o,
  input  logic                              ready_start_i,
  input  logic                              done_i,
  output logic                              evt_done_o,
  output logic                              busy_o,
  output logic [$clog2(JOB_FIFO_DEPTH):0]   jobs_pending_o,
  output logic [CNT_WIDTH-1:0]              jobs_done_o,
  output logic                              error_o
);

  ctrl_job_t            job_in;
  ctrl_job_t            job_head;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  job_sequencer_state_t state_q, state_d;
  logic                 evt_done_q;
  logic [CNT_WIDTH-1:0] jobs_done_q;

  // The queue stores fields at the package width; TRANS_WIDTH up to that width.
  assign job_in = '{
    base_addr:   job_base_addr_i,
    trans_size:  JOB_TRANS_WIDTH'(job_trans_size_i),
    line_stride: job_line_stride_i,
    line_length: JOB_TRANS_WIDTH'(job_line_length_i)
  };

  assign fifo_push   = job_valid_i & ~fifo_full;
  assign job_ready_o = ~fifo_full;

  hwpe_stream_job_fifo #(
    .DEPTH (JOB_FIFO_DEPTH)
  ) i_job_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (fifo_push),
    .data_i  (job_in),
    .pop_i   (fifo_pop),
    .data_o  (job_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (jobs_pending_o)
  );

  assign base_addr_o   = fifo_empty ? '0 : job_head.base_addr;
  assign trans_size_o  = fifo_empty ? '0 : TRANS_WIDTH'(job_head.trans_size);
  assign line_stride_o = fifo_empty ? '0 : job_head.line_stride;
  assign line_length_o = fifo_empty ? '0 : TRANS_WIDTH'(job_head.line_length);

  // IDLE also looks at a job being pushed into an empty queue so the start
  // request comes out the very next cycle.
  always_comb begin
    state_d     = state_q;
    req_start_o = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = (job_head.trans_size == '0) ? SKIP : ISSUE;
        end else if (fifo_push) begin
          state_d = (job_in.trans_size == '0) ? SKIP : ISSUE;
        end
      end
      ISSUE: begin
        req_start_o = ready_start_i;
        if (ready_start_i) state_d = RUN;
      end
      RUN: begin
        if (done_i) begin
          fifo_pop = 1'b1;
          state_d  = IDLE;
        end
      end
      SKIP: begin
        fifo_pop = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q     <= IDLE;
      evt_done_q  <= 1'b0;
      jobs_done_q <= '0;
    end else begin
      state_q    <= state_d;
      evt_done_q <= fifo_pop;
      if (fifo_pop) jobs_done_q <= jobs_done_q + 1'b1;
    end
  end

  assign evt_done_o  = evt_done_q;
  assign jobs_done_o = jobs_done_q;
  assign busy_o      = (state_q != IDLE) | ~fifo_empty;

  if (TIMEOUT_CYCLES > 0) begin : g_wdog
    localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WD_WIDTH-1:0] wd_cnt_q;
    logic                error_q;

    // wd_cnt_q counts RUN cycles already elapsed; it saturates at the last one.
    always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
        wd_cnt_q <= '0;
        error_q  <= 1'b0;
      end else if (state_q == ISSUE && ready_start_i) begin
        wd_cnt_q <= '0;
      end else if (state_q == RUN) begin
        if (wd_cnt_q == WD_LAST) begin
          if (!done_i) error_q <= 1'b1;
        end else begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
        end
      end
    end

    assign error_o = error_q;
  end else begin : g_no_wdog
    assign error_o = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_sink_job_sequencer.sv
`default_nettype none
// ============================================================================
// tb_hwpe_stream_sink_job_sequencer: vector table, directed corner sequences
// and random traffic against an event-timing reference model.  Revision: 1.0
// ============================================================================
module tb_hwpe_stream_sink_job_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 10;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  logic [31:0] job_base_addr_i = '0;
  logic [15:0] job_trans_size_i = '0;
  logic [15:0] job_line_stride_i = '0;
  logic [15:0] job_line_length_i = '0;
  logic [31:0] base_addr_o;
  logic [15:0] trans_size_o;
  logic [15:0] line_stride_o;
  logic [15:0] line_length_o;
  logic        req_start_o;
  logic        ready_start_i = 1'b0;
  logic        done_i = 1'b0;
  logic        evt_done_o;
  logic        busy_o;
  logic [2:0]  jobs_pending_o;
  logic [15:0] jobs_done_o;
  logic        error_o;

  hwpe_stream_sink_job_sequencer #(
    .JOB_FIFO_DEPTH (DEPTH),
    .TRANS_WIDTH    (16),
    .CNT_WIDTH      (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .clear_i           (clear_i),
    .job_valid_i       (job_valid_i),
    .job_ready_o       (job_ready_o),
    .job_base_addr_i   (job_base_addr_i),
    .job_trans_size_i  (job_trans_size_i),
    .job_line_stride_i (job_line_stride_i),
    .job_line_length_i (job_line_length_i),
    .base_addr_o       (base_addr_o),
    .trans_size_o      (trans_size_o),
    .line_stride_o     (line_stride_o),
    .line_length_o     (line_length_o),
    .req_start_o       (req_start_o),
    .ready_start_i     (ready_start_i),
    .done_i            (done_i),
    .evt_done_o        (evt_done_o),
    .busy_o            (busy_o),
    .jobs_pending_o    (jobs_pending_o),
    .jobs_done_o       (jobs_done_o),
    .error_o           (error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic to_neg;
    @(negedge clk_i);
  endtask

  task automatic to_next;
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply(input bit v, input logic [31:0] a, input logic [15:0] s,
                       input bit rs, input bit dn);
    job_valid_i       = v;
    job_base_addr_i   = a;
    job_trans_size_i  = s;
    job_line_stride_i = 16'h40;
    job_line_length_i = 16'h4;
    ready_start_i     = rs;
    done_i            = dn;
  endtask

  task automatic do_clear;
    apply(0, 0, 0, 0, 0);
    clear_i = 1'b1;
    to_next;
    clear_i = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          v;
    logic [31:0] addr;
    logic [15:0] size;
    bit          rs;
    bit          dn;
    bit          e_req;
    bit          e_evt;
    int          e_pend;
    bit          e_rdy;
    bit          e_busy;
    int          e_jd;
    logic [31:0] e_base;
  } vec_t;

  vec_t vt [25];

  function automatic vec_t mk(bit v, logic [31:0] a, logic [15:0] s, bit rs, bit dn,
                              bit rq, bit ev, int pd, bit rd, bit bz, int jd, logic [31:0] b);
    vec_t r;
    r = '{v, a, s, rs, dn, rq, ev, pd, rd, bz, jd, b};
    return r;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [15:0] size;
    logic [15:0] stride;
    logic [15:0] len;
    int          pcyc;
  } mjob_t;

  mjob_t       mq[$];
  int          cyc;
  int          prev_ret;
  int          start_cyc;
  bit          started;
  bit          m_evt;
  bit          m_err;
  int unsigned m_cnt;

  task automatic model_reset;
    mq.delete();
    started  = 0;
    m_evt    = 0;
    m_err    = 0;
    m_cnt    = 0;
    prev_ret = -10;
  endtask

  // A head job becomes eligible one cycle after it was pushed and two cycles
  // after the previous job retired, whichever is later.
  function automatic int elig();
    int a;
    int b;
    a = mq[0].pcyc + 1;
    b = prev_ret + 2;
    return (a > b) ? a : b;
  endfunction

  function automatic bit exp_start();
    if (mq.size() == 0 || started || mq[0].size == 16'd0) return 1'b0;
    return (cyc >= elig()) && ready_start_i;
  endfunction

  task automatic model_step(input bit st);
    bit pop;
    bit push;
    if (clear_i) begin
      model_reset();
    end else begin
      pop  = (mq.size() > 0) &&
             ((started && done_i) || (mq[0].size == 16'd0 && cyc >= elig()));
      push = job_valid_i && (mq.size() < DEPTH);
      if (started && !done_i && (cyc - start_cyc) == TO) m_err = 1;
      if (st) begin
        started   = 1;
        start_cyc = cyc;
      end
      m_evt = pop;
      if (pop) begin
        void'(mq.pop_front());
        m_cnt    = (m_cnt + 1) % 65536;
        prev_ret = cyc;
        started  = 0;
      end
      if (push)
        mq.push_back('{job_base_addr_i, job_trans_size_i, job_line_stride_i,
                       job_line_length_i, cyc});
    end
  endtask

  initial begin
    bit e_req;

    vt[0]  = mk(1, 32'h1000, 8, 1, 0,  0, 0, 0, 1, 0, 0, 32'h0);
    vt[1]  = mk(0, 0, 0, 1, 0,         1, 0, 1, 1, 1, 0, 32'h1000);
    vt[2]  = mk(0, 0, 0, 1, 0,         0, 0, 1, 1, 1, 0, 32'h1000);
    vt[3]  = mk(0, 0, 0, 1, 1,         0, 0, 1, 1, 1, 0, 32'h1000);
    vt[4]  = mk(0, 0, 0, 1, 0,         0, 1, 0, 1, 0, 1, 32'h0);
    vt[5]  = mk(0, 0, 0, 1, 0,         0, 0, 0, 1, 0, 1, 32'h0);
    vt[6]  = mk(1, 32'h2000, 4, 0, 0,  0, 0, 0, 1, 0, 1, 32'h0);
    vt[7]  = mk(0, 0, 0, 0, 0,         0, 0, 1, 1, 1, 1, 32'h2000);
    vt[8]  = mk(0, 0, 0, 0, 0,         0, 0, 1, 1, 1, 1, 32'h2000);
    vt[9]  = mk(0, 0, 0, 0, 0,         0, 0, 1, 1, 1, 1, 32'h2000);
    vt[10] = mk(0, 0, 0, 1, 0,         1, 0, 1, 1, 1, 1, 32'h2000);
    vt[11] = mk(0, 0, 0, 1, 0,         0, 0, 1, 1, 1, 1, 32'h2000);
    vt[12] = mk(0, 0, 0, 1, 1,         0, 0, 1, 1, 1, 1, 32'h2000);
    vt[13] = mk(0, 0, 0, 1, 0,         0, 1, 0, 1, 0, 2, 32'h0);
    vt[14] = mk(1, 32'h3000, 4, 1, 0,  0, 0, 0, 1, 0, 2, 32'h0);
    vt[15] = mk(1, 32'h4000, 0, 1, 0,  1, 0, 1, 1, 1, 2, 32'h3000);
    vt[16] = mk(1, 32'h5000, 4, 1, 0,  0, 0, 2, 1, 1, 2, 32'h3000);
    vt[17] = mk(0, 0, 0, 1, 1,         0, 0, 3, 1, 1, 2, 32'h3000);
    vt[18] = mk(0, 0, 0, 1, 0,         0, 1, 2, 1, 1, 3, 32'h4000);
    vt[19] = mk(0, 0, 0, 1, 0,         0, 0, 2, 1, 1, 3, 32'h4000);
    vt[20] = mk(0, 0, 0, 1, 0,         0, 1, 1, 1, 1, 4, 32'h5000);
    vt[21] = mk(0, 0, 0, 1, 0,         1, 0, 1, 1, 1, 4, 32'h5000);
    vt[22] = mk(0, 0, 0, 1, 0,         0, 0, 1, 1, 1, 4, 32'h5000);
    vt[23] = mk(0, 0, 0, 1, 1,         0, 0, 1, 1, 1, 4, 32'h5000);
    vt[24] = mk(0, 0, 0, 1, 0,         0, 1, 0, 1, 0, 5, 32'h0);

    // Reset state
    rst_ni = 1'b0;
    to_next;
    to_next;
    rst_ni = 1'b1;
    to_neg;
    chk("rst_ready", job_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_pending", jobs_pending_o, 0);
    chk("rst_jobs_done", jobs_done_o, 0);
    chk("rst_evt", evt_done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_req_start", req_start_o, 0);
    chk("rst_base_addr", base_addr_o, 0);
    chk("rst_trans_size", trans_size_o, 0);
    to_next;

    // Table: single job, ready_start stall, zero-size job between two jobs
    for (int i = 0; i < 25; i++) begin
      apply(vt[i].v, vt[i].addr, vt[i].size, vt[i].rs, vt[i].dn);
      to_neg;
      chk($sformatf("vec%0d_req_start", i), req_start_o, vt[i].e_req);
      chk($sformatf("vec%0d_evt", i), evt_done_o, vt[i].e_evt);
      chk($sformatf("vec%0d_pending", i), jobs_pending_o, vt[i].e_pend);
      chk($sformatf("vec%0d_ready", i), job_ready_o, vt[i].e_rdy);
      chk($sformatf("vec%0d_busy", i), busy_o, vt[i].e_busy);
      chk($sformatf("vec%0d_jobs_done", i), jobs_done_o, vt[i].e_jd);
      chk($sformatf("vec%0d_base", i), base_addr_o, vt[i].e_base);
      to_next;
    end
    do_clear;

    // Queue full: no pop bypass, ready re-raised after retire
    for (int k = 0; k < 4; k++) begin
      apply(1, 32'h100 * (k + 1), 16'd16, 1, 0);
      to_neg;
      to_next;
    end
    apply(1, 32'h500, 16'd16, 1, 0);
    to_neg;
    chk("full_ready", job_ready_o, 0);
    chk("full_pending", jobs_pending_o, 4);
    chk("full_head", base_addr_o, 32'h100);
    to_next;
    to_neg;
    chk("full_hold_pending", jobs_pending_o, 4);
    to_next;
    done_i = 1'b1;
    to_neg;
    chk("full_no_bypass", job_ready_o, 0);
    to_next;
    done_i = 1'b0;
    to_neg;
    chk("full_retire_pending", jobs_pending_o, 3);
    chk("full_retire_ready", job_ready_o, 1);
    chk("full_retire_head", base_addr_o, 32'h200);
    chk("full_retire_evt", evt_done_o, 1);
    to_next;
    job_valid_i = 1'b0;
    to_neg;
    chk("full_refill_pending", jobs_pending_o, 4);
    to_next;
    do_clear;

    // Watchdog timeout, stickiness and clear
    apply(1, 32'h600, 16'd8, 1, 0);
    to_next;
    job_valid_i = 1'b0;
    to_next;
    for (int r = 1; r <= TO; r++) begin
      to_neg;
      chk($sformatf("wdog_run%0d_error", r), error_o, 0);
      to_next;
    end
    for (int r = 0; r < 3; r++) begin
      to_neg;
      chk("wdog_error_set", error_o, 1);
      chk("wdog_still_busy", busy_o, 1);
      to_next;
    end
    clear_i = 1'b1;
    to_next;
    clear_i = 1'b0;
    to_neg;
    chk("wdog_clear_error", error_o, 0);
    chk("wdog_clear_pending", jobs_pending_o, 0);
    chk("wdog_clear_busy", busy_o, 0);
    to_next;

    // done_i on the limit cycle wins over the timeout
    apply(1, 32'h700, 16'd8, 1, 0);
    to_next;
    job_valid_i = 1'b0;
    to_next;
    for (int r = 1; r < TO; r++) to_next;
    done_i = 1'b1;
    to_next;
    done_i = 1'b0;
    to_neg;
    chk("wdog_done_wins_error", error_o, 0);
    chk("wdog_done_wins_evt", evt_done_o, 1);
    to_next;
    to_neg;
    chk("wdog_done_wins_later", error_o, 0);
    to_next;
    do_clear;

    // Clear mid-RUN then a stray done; then the same with a reset pulse
    for (int m = 0; m < 2; m++) begin
      apply(1, 32'h800, 16'd8, 1, 0);
      to_next;
      job_valid_i = 1'b0;
      to_next;
      to_next;
      if (m == 0) clear_i = 1'b1;
      else rst_ni = 1'b0;
      to_next;
      clear_i = 1'b0;
      rst_ni  = 1'b1;
      done_i  = 1'b1;
      to_neg;
      chk($sformatf("abort%0d_evt0", m), evt_done_o, 0);
      chk($sformatf("abort%0d_pending", m), jobs_pending_o, 0);
      to_next;
      done_i = 1'b0;
      to_neg;
      chk($sformatf("abort%0d_evt1", m), evt_done_o, 0);
      chk($sformatf("abort%0d_jobs_done", m), jobs_done_o, 0);
      chk($sformatf("abort%0d_busy", m), busy_o, 0);
      chk($sformatf("abort%0d_req", m), req_start_o, 0);
      to_next;
    end

    // Random traffic against the reference model
    do_clear;
    model_reset();
    cyc = 0;
    for (int c = 0; c < 3000; c++) begin
      job_valid_i       = ($urandom_range(99) < 35);
      job_base_addr_i   = $urandom();
      job_trans_size_i  = ($urandom_range(4) == 0) ? 16'd0 : 16'($urandom_range(200, 1));
      job_line_stride_i = 16'($urandom());
      job_line_length_i = 16'($urandom());
      ready_start_i     = ($urandom_range(99) < 70);
      done_i            = started ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      clear_i           = ($urandom_range(299) == 0);
      to_neg;
      e_req = exp_start();
      chk("rnd_req_start", req_start_o, e_req);
      chk("rnd_pending", jobs_pending_o, mq.size());
      chk("rnd_ready", job_ready_o, mq.size() < DEPTH);
      chk("rnd_busy", busy_o, mq.size() != 0);
      chk("rnd_evt", evt_done_o, m_evt);
      chk("rnd_jobs_done", jobs_done_o, m_cnt);
      chk("rnd_error", error_o, m_err);
      chk("rnd_base", base_addr_o, (mq.size() != 0) ? mq[0].addr : 32'h0);
      chk("rnd_size", trans_size_o, (mq.size() != 0) ? mq[0].size : 16'h0);
      chk("rnd_stride", line_stride_o, (mq.size() != 0) ? mq[0].stride : 16'h0);
      chk("rnd_len", line_length_o, (mq.size() != 0) ? mq[0].len : 16'h0);
      model_step(e_req);
      to_next;
      cyc++;
    end
    clear_i     = 1'b0;
    done_i      = 1'b0;
    job_valid_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
